// File: rtl/m_fetch_queue_pkg.sv
// Shared constants and FSM state type for the instruction-fetch front end.
package m_fetch_queue_pkg;

  localparam logic [31:0] HALT_INSTR = 32'h000f0033;
  localparam logic [31:0] NOP_INSTR  = 32'h00000013;
  localparam int unsigned IMEM_AW    = 12;

  typedef enum logic {
    FETCH = 1'b0,
    HALT  = 1'b1
  } state_e;

endpackage

// File: rtl/m_fetch_queue_if.sv
// Fetch-side bus: instruction memory port, execute redirect, decode handshake.
interface m_fetch_queue_if;
  import m_fetch_queue_pkg::*;

  logic               redirect;
  logic [31:0]        redirect_pc;
  logic [IMEM_AW-1:0] imem_addr;
  logic [31:0]        imem_rdata;
  logic               out_valid;
  logic [31:0]        out_pc;
  logic [31:0]        out_instr;
  logic               out_ready;
  logic               halted;

  modport master (
    input  redirect, redirect_pc, imem_rdata, out_ready,
    output imem_addr, out_valid, out_pc, out_instr, halted
  );

  modport slave (
    output redirect, redirect_pc, imem_rdata, out_ready,
    input  imem_addr, out_valid, out_pc, out_instr, halted
  );

endinterface

// File: rtl/m_fetch_fifo.sv
// DEPTH-entry {pc, instr} queue; power-of-two DEPTH so pointers wrap naturally.
module m_fetch_fifo
  import m_fetch_queue_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PW    = $clog2(DEPTH),
  localparam int unsigned CW    = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          flush_i,
  input  logic [63:0]   wdata_i,
  output logic [63:0]   rdata_o,
  output logic [CW-1:0] count_o,
  output logic          valid_o
);

  logic [63:0]   mem_q [DEPTH];
  logic [PW-1:0] head_q, tail_q;
  logic [CW-1:0] count_q;

  always_ff @(posedge clk) begin
    if (push_i) mem_q[tail_q] <= wdata_i;
  end

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_i) tail_q <= tail_q + 1'b1;
      if (pop_i)  head_q <= head_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Credit in the parent guarantees a free slot for every response.
  always_ff @(posedge clk) begin
    if (!rst) assert (!(push_i && !flush_i && count_q == CW'(DEPTH)));
  end

  assign valid_o = (count_q != '0);
  assign count_o = count_q;
  assign rdata_o = valid_o ? mem_q[head_q] : {32'h0, NOP_INSTR};

endmodule

// File: rtl/m_fetch_queue.sv
// Instruction fetch front end: synchronous imem requests, credit-limited queue, redirect flush.
// Optional halt-word detection enabled by defining IF_HALT_DETECT_EN.
module m_fetch_queue
  import m_fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input logic             clk,
  input logic             rst,
  input logic             ce,
  m_fetch_queue_if.master bus
);

  localparam int unsigned CW  = $clog2(DEPTH) + 1;
  localparam int unsigned CRW = CW + 1;
  localparam logic [CRW-1:0] DEPTH_CR = CRW'(DEPTH);

  state_e        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic          inflight_q, inflight_d;
  logic          kill_q, kill_d;
  logic [CW-1:0] count;
  logic [CRW-1:0] credit;
  logic [63:0]   head;
  logic          fifo_valid, push, pop, flush, issue, halt_cap;

  assign flush  = ce & bus.redirect;
  assign pop    = ce & fifo_valid & bus.out_ready & ~bus.redirect;
  assign push   = ce & inflight_q & ~kill_q & ~bus.redirect;
  assign credit = CRW'(count) + CRW'(inflight_q);
  assign issue  = ce & (state_q == FETCH) & ~bus.redirect &
                  ((credit < DEPTH_CR) | ((credit == DEPTH_CR) & pop));

`ifdef IF_HALT_DETECT_EN
  assign halt_cap = push & (state_q == FETCH) & (bus.imem_rdata == HALT_INSTR);
`else
  assign halt_cap = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    inflight_d = inflight_q;
    kill_d     = kill_q;
    if (ce) begin
      if (bus.redirect) begin
        state_d    = FETCH;
        fetch_pc_d = {bus.redirect_pc[31:2], 2'b00};
        inflight_d = 1'b0;
        kill_d     = 1'b0;
      end else begin
        inflight_d = issue;
        kill_d     = 1'b0;
        if (issue) begin
          fetch_pc_d = fetch_pc_q + 32'd4;
          resp_pc_d  = fetch_pc_q;
        end
        // A request issued alongside the halt capture is dropped on return.
        if (halt_cap) begin
          state_d    = HALT;
          fetch_pc_d = resp_pc_q + 32'd4;
          kill_d     = issue;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FETCH;
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= '0;
      inflight_q <= 1'b0;
      kill_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      inflight_q <= inflight_d;
      kill_q     <= kill_d;
    end
  end

  m_fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (flush),
    .wdata_i ({resp_pc_q, bus.imem_rdata}),
    .rdata_o (head),
    .count_o (count),
    .valid_o (fifo_valid)
  );

  assign bus.imem_addr = fetch_pc_q[IMEM_AW+1:2];
  assign bus.out_valid = fifo_valid;
  assign bus.out_pc    = head[63:32];
  assign bus.out_instr = head[31:0];
  assign bus.halted    = (state_q == HALT);

endmodule

// File: tb/tb_m_fetch_queue.sv
// Directed bench for m_fetch_queue with a ce-gated synchronous instruction memory model.
module tb_m_fetch_queue;
  import m_fetch_queue_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic ce;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] mem [4096];

  m_fetch_queue_if fq_if ();

  m_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk (clk),
    .rst (rst),
    .ce  (ce),
    .bus (fq_if)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ce) fq_if.imem_rdata <= mem[fq_if.imem_addr];
  end

  function automatic logic [31:0] ins(input logic [31:0] pc);
    return {pc[13:2], 20'h00093};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_head(input string tag, input logic [31:0] pc);
    chk({tag, "_valid"}, 32'(fq_if.out_valid), 32'd1);
    chk({tag, "_pc"}, fq_if.out_pc, pc);
    chk({tag, "_instr"}, fq_if.out_instr, ins(pc));
  endtask

  initial begin
    rst = 1'b1;
    ce  = 1'b1;
    fq_if.redirect    = 1'b0;
    fq_if.redirect_pc = '0;
    fq_if.out_ready   = 1'b0;
    fq_if.imem_rdata  = '0;
    for (int unsigned i = 0; i < 4096; i++) mem[i] = {i[11:0], 20'h00093};

    repeat (3) tick();
    chk("rst_valid", 32'(fq_if.out_valid), 32'd0);
    chk("rst_halted", 32'(fq_if.halted), 32'd0);
    chk("rst_addr", 32'(fq_if.imem_addr), 32'd0);
    chk("rst_pc", fq_if.out_pc, 32'h0);
    chk("rst_instr", fq_if.out_instr, NOP_INSTR);

    // Streaming from reset: first head on the third cycle, then one per cycle.
    rst = 1'b0;
    fq_if.out_ready = 1'b1;
    tick();
    chk("fill_gap", 32'(fq_if.out_valid), 32'd0);
    chk("fill_addr", 32'(fq_if.imem_addr), 32'd1);
    for (int j = 0; j < 6; j++) begin
      tick();
      chk_head("stream", 32'(4 * j));
    end

    // Decode stall: queue fills to DEPTH, fetch stops at pc 0x24.
    fq_if.out_ready = 1'b0;
    for (int j = 0; j < 10; j++) begin
      tick();
      chk_head("stall", 32'h14);
    end
    chk("stall_addr", 32'(fq_if.imem_addr), 32'd9);
    fq_if.out_ready = 1'b1;
    for (int j = 1; j < 6; j++) begin
      tick();
      chk_head("release", 32'(32'h14 + 4 * j));
    end

    // Redirect with a full pipeline and a concurrent pop.
    fq_if.redirect    = 1'b1;
    fq_if.redirect_pc = 32'h40;
    tick();
    fq_if.redirect = 1'b0;
    chk("redir_gap0", 32'(fq_if.out_valid), 32'd0);
    chk("redir_addr", 32'(fq_if.imem_addr), 32'h10);
    tick();
    chk("redir_gap1", 32'(fq_if.out_valid), 32'd0);
    tick();
    chk_head("redir_first", 32'h40);
    tick();
    chk_head("redir_next", 32'h44);

    // Clock-enable freeze with a read in flight.
    ce = 1'b0;
    for (int j = 0; j < 5; j++) begin
      tick();
      chk_head("ce_hold", 32'h44);
      chk("ce_addr", 32'(fq_if.imem_addr), 32'h13);
    end
    ce = 1'b1;
    tick();
    chk_head("ce_resume", 32'h48);
    tick();
    chk_head("ce_resume2", 32'h4c);

    // Misaligned redirect target.
    fq_if.redirect    = 1'b1;
    fq_if.redirect_pc = 32'h42;
    tick();
    fq_if.redirect = 1'b0;
    chk("align_gap0", 32'(fq_if.out_valid), 32'd0);
    chk("align_addr", 32'(fq_if.imem_addr), 32'h10);
    tick();
    chk("align_gap1", 32'(fq_if.out_valid), 32'd0);
    tick();
    chk_head("align_first", 32'h40);

    // Halt word at 0x10.
    mem[4] = HALT_INSTR;
    fq_if.redirect    = 1'b1;
    fq_if.redirect_pc = 32'h0;
    tick();
    fq_if.redirect = 1'b0;
    tick();
    for (int j = 0; j < 4; j++) begin
      tick();
      chk_head("pre_halt", 32'(4 * j));
    end
    tick();
    chk("halt_word_valid", 32'(fq_if.out_valid), 32'd1);
    chk("halt_word_pc", fq_if.out_pc, 32'h10);
    chk("halt_word_instr", fq_if.out_instr, HALT_INSTR);
`ifdef IF_HALT_DETECT_EN
    chk("halt_set", 32'(fq_if.halted), 32'd1);
    tick();
    chk("halt_empty", 32'(fq_if.out_valid), 32'd0);
    chk("halt_hold", 32'(fq_if.halted), 32'd1);
    chk("halt_addr", 32'(fq_if.imem_addr), 32'd5);
    tick();
    chk("halt_empty2", 32'(fq_if.out_valid), 32'd0);
    chk("halt_addr2", 32'(fq_if.imem_addr), 32'd5);
`else
    chk("nohalt_flag", 32'(fq_if.halted), 32'd0);
    tick();
    chk_head("nohalt_next", 32'h14);
    tick();
    chk_head("nohalt_next2", 32'h18);
`endif

    fq_if.redirect    = 1'b1;
    fq_if.redirect_pc = 32'h0;
    tick();
    fq_if.redirect = 1'b0;
    chk("unhalt", 32'(fq_if.halted), 32'd0);
    tick();
    tick();
    chk_head("restart", 32'h0);

    // Mid-stream reset.
    rst = 1'b1;
    tick();
    chk("mrst_valid", 32'(fq_if.out_valid), 32'd0);
    chk("mrst_halted", 32'(fq_if.halted), 32'd0);
    chk("mrst_addr", 32'(fq_if.imem_addr), 32'd0);
    chk("mrst_pc", fq_if.out_pc, 32'h0);
    chk("mrst_instr", fq_if.out_instr, NOP_INSTR);
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
